// File: rtl/sp_ram_arbiter.sv
// Two-requester round-robin arbiter sharing one single-port RAM, with tagged read return.
// Optional grant statistics and contention flag when SP_RAM_ARB_STATS_EN is defined.
module sp_ram_arbiter #(
    parameter int DW     = 8,
    parameter int AW     = 6,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] ram_data,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    input  logic [DW-1:0] ram_q
`ifdef SP_RAM_ARB_STATS_EN
    ,
    output logic [15:0]   gcnt0,
    output logic [15:0]   gcnt1,
    output logic          conflict
`endif
);

    logic               last_reg;
    logic               last_next;
    logic [AW-1:0]      addr_hold_reg;
    logic [DW-1:0]      data_hold_reg;
    logic [RD_LAT-1:0]  pipe_vld_reg;
    logic [RD_LAT-1:0]  pipe_id_reg;
    logic               rvalid0_reg;
    logic               rvalid1_reg;
    logic [DW-1:0]      rdata0_reg;
    logic [DW-1:0]      rdata1_reg;
    logic               rd_issue;

    // Pointer reset to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_reg <= 1'b1;
        end else begin
            last_reg <= last_next;
        end
    end

    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        last_next = last_reg;
        if (!rst) begin
            if (req0 && (!req1 || last_reg)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
        if (gnt0) begin
            last_next = 1'b0;
        end else if (gnt1) begin
            last_next = 1'b1;
        end
    end

    // Idle cycles present the last granted address/data so the RAM never sees X.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = addr_hold_reg;
        ram_data = data_hold_reg;
        if (gnt0) begin
            ram_we   = we0;
            ram_addr = addr0;
            ram_data = wdata0;
        end else if (gnt1) begin
            ram_we   = we1;
            ram_addr = addr1;
            ram_data = wdata1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_hold_reg <= '0;
            data_hold_reg <= '0;
        end else if (gnt0 || gnt1) begin
            addr_hold_reg <= ram_addr;
            data_hold_reg <= ram_data;
        end
    end

    assign rd_issue = (gnt0 && !we0) || (gnt1 && !we1);

    // Tag pipeline tracks each read until ram_q is valid for it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_reg <= '0;
            pipe_id_reg  <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                pipe_vld_reg[i] <= pipe_vld_reg[i-1];
                pipe_id_reg[i]  <= pipe_id_reg[i-1];
            end
            pipe_vld_reg[0] <= rd_issue;
            pipe_id_reg[0]  <= gnt1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid0_reg <= 1'b0;
            rvalid1_reg <= 1'b0;
            rdata0_reg  <= '0;
            rdata1_reg  <= '0;
        end else begin
            rvalid0_reg <= pipe_vld_reg[RD_LAT-1] && !pipe_id_reg[RD_LAT-1];
            rvalid1_reg <= pipe_vld_reg[RD_LAT-1] &&  pipe_id_reg[RD_LAT-1];
            if (pipe_vld_reg[RD_LAT-1] && !pipe_id_reg[RD_LAT-1]) begin
                rdata0_reg <= ram_q;
            end
            if (pipe_vld_reg[RD_LAT-1] && pipe_id_reg[RD_LAT-1]) begin
                rdata1_reg <= ram_q;
            end
        end
    end

    // Return outputs read as zero for the whole time reset is held.
    assign rvalid0 = rvalid0_reg && !rst;
    assign rvalid1 = rvalid1_reg && !rst;
    assign rdata0  = rst ? '0 : rdata0_reg;
    assign rdata1  = rst ? '0 : rdata1_reg;

`ifdef SP_RAM_ARB_STATS_EN
    logic [15:0] gcnt0_reg;
    logic [15:0] gcnt1_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            gcnt0_reg <= '0;
            gcnt1_reg <= '0;
        end else begin
            if (gnt0 && gcnt0_reg != 16'hFFFF) begin
                gcnt0_reg <= gcnt0_reg + 16'd1;
            end
            if (gnt1 && gcnt1_reg != 16'hFFFF) begin
                gcnt1_reg <= gcnt1_reg + 16'd1;
            end
        end
    end

    assign gcnt0    = gcnt0_reg;
    assign gcnt1    = gcnt1_reg;
    assign conflict = req0 && req1;
`endif

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Randomized bench for sp_ram_arbiter: RAM model plus a scoreboard of expected grants and returns.
// Stats checks are compiled in when SP_RAM_ARB_STATS_EN is defined.
module tb_sp_ram_arbiter;

    localparam int DW     = 8;
    localparam int AW     = 6;
    localparam int RD_LAT = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [DW-1:0] ram_data, ram_q;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
`ifdef SP_RAM_ARB_STATS_EN
    logic [15:0]   gcnt0, gcnt1;
    logic          conflict;
`endif

    always #5 clk = ~clk;

    sp_ram_arbiter #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q)
`ifdef SP_RAM_ARB_STATS_EN
        , .gcnt0(gcnt0), .gcnt1(gcnt1), .conflict(conflict)
`endif
    );

    // Single-port RAM: command captured at the edge, q valid RD_LAT cycles later.
    logic [DW-1:0] mem    [64];
    logic [DW-1:0] q_pipe [RD_LAT];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        q_pipe[0] <= mem[ram_addr];
        for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
    end
    assign ram_q = q_pipe[RD_LAT-1];

    // Reference model state
    typedef struct {
        int            due;
        bit            id;
        logic [DW-1:0] d;
    } rd_t;
    rd_t           rq[$];
    logic [DW-1:0] golden [64];
    int            pri;        // requester that wins the next contention
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_data;
    logic [DW-1:0] exp_rd0, exp_rd1;
    int            gc0, gc1, n_conf;
    int            cyc;
    bit            g0_seen, g1_seen;
    int            n_checks, n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // One clock: check outputs mid-cycle, then advance the model across the edge.
    task automatic step();
        bit            e0, e1, ev0, ev1;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        bit            ewe;
        @(negedge clk);
        e0  = !rst && req0 && (!req1 || pri == 0);
        e1  = !rst && req1 && !e0;
        ea  = e0 ? addr0  : (e1 ? addr1  : h_addr);
        ed  = e0 ? wdata0 : (e1 ? wdata1 : h_data);
        ewe = (e0 && we0) || (e1 && we1);
        check("gnt0", 32'(gnt0), 32'(e0));
        check("gnt1", 32'(gnt1), 32'(e1));
        check("ram_we", 32'(ram_we), 32'(ewe));
        check("ram_addr", 32'(ram_addr), 32'(ea));
        check("ram_data", 32'(ram_data), 32'(ed));
        ev0 = 1'b0;
        ev1 = 1'b0;
        if (!rst && rq.size() > 0 && rq[0].due == cyc) begin
            if (rq[0].id) begin ev1 = 1'b1; exp_rd1 = rq[0].d; end
            else          begin ev0 = 1'b1; exp_rd0 = rq[0].d; end
            void'(rq.pop_front());
        end
        check("rvalid0", 32'(rvalid0), 32'(ev0));
        check("rvalid1", 32'(rvalid1), 32'(ev1));
        check("rdata0", 32'(rdata0), rst ? 32'd0 : 32'(exp_rd0));
        check("rdata1", 32'(rdata1), rst ? 32'd0 : 32'(exp_rd1));
`ifdef SP_RAM_ARB_STATS_EN
        check("conflict", 32'(conflict), 32'(req0 && req1));
        check("gcnt0", 32'(gcnt0), 32'(gc0));
        check("gcnt1", 32'(gcnt1), 32'(gc1));
`endif
        if (req0 && req1) n_conf++;
        if (rst) begin
            pri = 0; rq.delete(); exp_rd0 = '0; exp_rd1 = '0;
            h_addr = '0; h_data = '0; gc0 = 0; gc1 = 0;
        end else if (e0 || e1) begin
            pri    = e0 ? 1 : 0;
            h_addr = ea;
            h_data = ed;
            if (e0 && gc0 < 65535) gc0++;
            if (e1 && gc1 < 65535) gc1++;
            if (ewe) golden[ea] = ed;
            else     rq.push_back('{due: cyc + RD_LAT + 1, id: e1, d: golden[ea]});
        end
        g0_seen = e0;
        g1_seen = e1;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic set0(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req0 = r; we0 = w; addr0 = a; wdata0 = d;
    endtask

    task automatic set1(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req1 = r; we1 = w; addr1 = a; wdata1 = d;
    endtask

    task automatic idle(input int n);
        set0(0, 0, '0, '0);
        set1(0, 0, '0, '0);
        repeat (n) step();
    endtask

    bit            pend0, pend1;
    bit            cw0, cw1;
    logic [AW-1:0] ca0, ca1;
    logic [DW-1:0] cd0, cd1;

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0;
        pri = 0; h_addr = '0; h_data = '0; exp_rd0 = '0; exp_rd1 = '0;
        gc0 = 0; gc1 = 0; n_conf = 0;
        for (int i = 0; i < 64; i++) golden[i] = 'x;
        rst = 1'b1;
        set0(0, 0, '0, '0);
        set1(0, 0, '0, '0);
        @(posedge clk);
        #1;
        step();
        step();
        rst = 1'b0;

        // Fill the whole RAM so every later read has a defined value.
        for (int a = 0; a < 64; a++) begin
            set0(1, 1, AW'(a), DW'($urandom));
            step();
        end
        idle(1);

        // Write then read same address back to back.
        set0(1, 1, 6'h05, 8'hA5); step();
        set0(1, 0, 6'h05, 8'h00); step();
        idle(RD_LAT + 2);

        // Alternating reads under contention.
        set0(1, 1, 6'h01, 8'h11); step();
        idle(0);
        set0(0, 0, '0, '0);
        set1(1, 1, 6'h02, 8'h22); step();
        set0(1, 0, 6'h01, 8'h00);
        set1(1, 0, 6'h02, 8'h00);
        repeat (4) step();
        idle(RD_LAT + 2);

        // Lone requester 1, then contention.
        set1(1, 0, 6'h10, 8'h00);
        repeat (3) step();
        set0(1, 0, 6'h11, 8'h00);
        repeat (2) step();
        idle(RD_LAT + 2);

        // Write by 0 wins, pending read of same address by 1 sees new data.
        set0(1, 1, 6'h3F, 8'h5A);
        set1(1, 0, 6'h3F, 8'h00);
        step();
        set0(0, 0, '0, '0);
        step();
        idle(RD_LAT + 2);

        // Reset right after a read is granted.
        idle(0);
        set1(1, 0, 6'h3F, 8'h00); step();
        set1(0, 0, '0, '0);
        rst = 1'b1; step(); step();
        rst = 1'b0;
        set0(1, 0, 6'h05, 8'h00);
        set1(1, 0, 6'h3F, 8'h00);
        repeat (2) step();
        idle(RD_LAT + 2);

        // Stats scenario: 2 contention cycles, 3 grants to 0 and 2 to 1, then reset.
        rst = 1'b1; step(); rst = 1'b0;
        n_conf = 0;
        set0(1, 0, 6'h01, 8'h00);
        set1(1, 0, 6'h02, 8'h00);
        repeat (2) step();
        set1(0, 0, '0, '0);
        repeat (2) step();
        set0(0, 0, '0, '0);
        set1(1, 0, 6'h02, 8'h00);
        step();
        idle(RD_LAT + 2);
        check("gc0_model", 32'(gc0), 32'd3);
        check("gc1_model", 32'(gc1), 32'd2);
        check("conf_cycles", 32'(n_conf), 32'd2);
        rst = 1'b1; step(); rst = 1'b0;
        idle(2);

        // Random clients honoring the hold-until-granted handshake.
        pend0 = 0; pend1 = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!pend0 && $urandom_range(0, 2) != 0) begin
                pend0 = 1; cw0 = 1'($urandom_range(0, 1));
                ca0 = AW'($urandom_range(0, 15)); cd0 = DW'($urandom);
            end
            if (!pend1 && $urandom_range(0, 2) != 0) begin
                pend1 = 1; cw1 = 1'($urandom_range(0, 1));
                ca1 = AW'($urandom_range(0, 15)); cd1 = DW'($urandom);
            end
            set0(pend0, pend0 ? cw0 : 1'b0, pend0 ? ca0 : AW'($urandom), DW'($urandom));
            if (pend0) wdata0 = cd0;
            set1(pend1, pend1 ? cw1 : 1'b0, pend1 ? ca1 : AW'($urandom), DW'($urandom));
            if (pend1) wdata1 = cd1;
            rst = ($urandom_range(0, 99) == 0);
            step();
            if (g0_seen) pend0 = 0;
            if (g1_seen) pend1 = 0;
        end
        rst = 1'b0;
        idle(RD_LAT + 3);
        check("queue_drained", 32'(rq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sp_ram_arbiter.md
Name: sp_ram_arbiter

Overview:
Two-requester round-robin arbiter that shares one single_port_ram (8-bit data, 6-bit address, 64 words) between two independent clients.
- Muxes one client's command onto the RAM port each cycle.
- Tracks outstanding reads and returns read data with a tagged valid to the issuing client.
- Sits directly in front of the RAM; clients never drive the RAM themselves.

Parameters:
DW, 8, data width; must match RAM data width.
AW, 6, address width; must match RAM address width (64 words).
RD_LAT, 1, cycles from RAM command capture edge to valid ram_q; range 1..4.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous reset, active-high.
req0  input  1  requester 0 command request; held with its command until granted.
we0  input  1  requester 0 write enable (1 = write, 0 = read).
addr0  input  AW  requester 0 address.
wdata0  input  DW  requester 0 write data.
gnt0  output  1  requester 0 grant; command accepted at this cycle's clk edge.
rvalid0  output  1  requester 0 read data valid, one-cycle pulse.
rdata0  output  DW  requester 0 read data.
req1/we1/addr1/wdata1/gnt1/rvalid1/rdata1  same as above, for requester 1.
ram_data  output  DW  to RAM data.
ram_addr  output  AW  to RAM addr.
ram_we  output  1  to RAM we.
ram_q  input  DW  from RAM q.

Behaviour:
Reset (rst=1):
- gnt0=gnt1=0, ram_we=0, rvalid0=rvalid1=0, rdata0=rdata1=0.
- Read pipeline flushed, so no rvalid is produced for commands issued before or during reset.
- Priority pointer set so requester 0 wins the first contention.

Arbitration (combinational from req0/req1 and the registered pointer `last`):
- Only one requester active: it is granted.
- Both active: the requester not equal to `last` is granted.
- Neither active: no grant, ram_we=0, ram_addr/ram_data hold their previous values (registered hold, no X).
- `last` updates to the granted index at the clk edge; unchanged when no grant.
- At most one of gnt0/gnt1 is high in any cycle.

Command path:
- ram_addr/ram_data/ram_we come combinationally from the granted requester's addr/wdata/we.
- ram_we=1 only when the granted requester has we=1.
- One access per cycle; back-to-back grants to the same or alternating requesters are allowed.

Client handshake:
- A client may drop req or change its command only after the cycle in which its gnt=1.
- req held without a grant keeps the command pending indefinitely.

Read return:
- Each granted read (we=0) pushes {valid=1, id} into an RD_LAT-deep shift pipeline.
- Writes push valid=0.
- At pipeline output: rdata[id] <= ram_q, rvalid[id] <= 1 for one cycle; the other client's rvalid stays 0.
- rvalid occurs RD_LAT+1 cycles after the gnt cycle, including the output register.
- Reads return in issue order.
- rdataN holds its last value when rvalidN=0.

Ordering and hazards:
- A write granted in cycle N followed by a read of the same address in cycle N+1 returns the new data.
- Both clients may target the same address; ordering is grant order.

Reset mid-operation:
- Outstanding reads are discarded.
- After rst deasserts, the first grant obeys the reset pointer (requester 0 first on contention).

Optional Feature:
Macro: SP_RAM_ARB_STATS_EN.
Defined:
- Adds outputs gcnt0 and gcnt1 (16 bits each).
- Each counts grants to its requester and saturates at 16'hFFFF.
- Cleared by rst.
- Adds output conflict (1 bit): high in any cycle where req0 and req1 are both 1.
Undefined:
- These ports and counters do not exist.
- All other behaviour is identical.

Test Plan:
1. Reset, then req0 write addr=6'h05 wdata=8'hA5; next cycle req0 read addr=6'h05 -> gnt0 both cycles; rvalid0=1 with rdata0=8'hA5 exactly RD_LAT+1 cycles after the read gnt; rvalid1 stays 0.
2. req0 and req1 both held as reads of addr 6'h01/6'h02 (preloaded 8'h11/8'h22) for 4 cycles -> grants alternate 0,1,0,1 starting with 0; rdata returns 11,22,11,22 on the matching rvalid lines in order.
3. Only req1 asserted for 3 cycles -> gnt1 every cycle, gnt0=0; then both asserted -> gnt0 first.
4. Cycle N: req0 write addr 6'h3F data 8'h5A wins; req1 read addr 6'h3F pending, granted N+1 -> rdata1=8'h5A.
5. Issue read on req1, assert rst the next cycle -> no rvalid1 pulse; all outputs 0; after release, contention grants requester 0 first.
6. With SP_RAM_ARB_STATS_EN: 3 grants to 0, 2 to 1 with 2 contention cycles -> gcnt0=3, gcnt1=2, conflict high in exactly 2 cycles; rst clears both counters.
